// File: rtl/mcu_core_pkg.sv
// Shared types for the mcu_core_p accumulator core: opcodes, FSM states, ALU decode.
package mcu_core_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDA  = 4'h2,
    OP_STA  = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JC   = 4'hB,
    OP_CALL = 4'hC,
    OP_RET  = 4'hD,
    OP_SHL  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Operation applied to ACC and the memory operand when a data access completes.
  // ALU_NONE marks a memory op that does not touch ACC (STA) or a non-memory op.
  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_NONE = 3'd6
  } alu_op_e;

  function automatic alu_op_e alu_decode(input opcode_e op);
    case (op)
      OP_LDA:  return ALU_PASS;
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_NONE;
    endcase
  endfunction

  // Opcodes that need a data-memory cycle after EXEC.
  function automatic logic uses_mem(input opcode_e op);
    return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/mcu_call_stack.sv
// Return-address LIFO. Push when full and pop when empty are dropped here;
// the core decides what an overflow/underflow means architecturally.
module mcu_call_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int SP_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] entries_q [DEPTH];
  logic [ADDR_W-1:0] entries_d [DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;

  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == '0);

  // Top-of-stack read and push/pop pointer update.
  always_comb begin
    entries_d = entries_q;
    sp_d      = sp_q;
    top       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) top = entries_q[i];
    end
    if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sp_q == SP_W'(i)) entries_d[i] = push_data;
      end
      sp_d = sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  // Stack storage and pointer, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      sp_q      <= sp_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/mcu_core_p.sv
// Parametrised accumulator core: FETCH/EXEC/MEM FSM, ALU, flags and call stack.
// Handshakes (both ports): req, addr, we and wdata stay stable from req rising
// until the cycle in which ack is high; the transfer completes on that edge and
// req is low the following cycle. Ack while req is low has no effect.
module mcu_core_p
  import mcu_core_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [ADDR_W+3:0]   imem_rdata,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic                dmem_ack,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic [DATA_W-1:0]   acc_out,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                z_flag,
  output logic                c_flag,
  output logic                halted,
  output logic                stack_err,
  output logic [1:0]          state_out
);

  localparam int IW = ADDR_W + 4;

  state_e            state_q, state_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic              err_q, err_d;

  opcode_e           op;
  alu_op_e           aop;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] ldi_val, shl_val, alu_res;
  logic              alu_c;
  logic [DATA_W:0]   sum_w, diff_w;

  logic              st_push, st_pop, st_full, st_empty;
  logic [ADDR_W-1:0] st_top;

  assign op      = opcode_e'(ir_q[IW-1 -: 4]);
  assign operand = ir_q[ADDR_W-1:0];
  assign aop     = alu_decode(op);
  assign ldi_val = DATA_W'(operand);
  assign shl_val = {acc_q[DATA_W-2:0], 1'b0};
  // Borrow of ACC-mem falls out as the extra top bit of the widened difference.
  assign sum_w   = {1'b0, acc_q} + {1'b0, dmem_rdata};
  assign diff_w  = {1'b0, acc_q} - {1'b0, dmem_rdata};

  mcu_call_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (st_push),
    .pop       (st_pop),
    .push_data (pc_q),
    .top       (st_top),
    .full      (st_full),
    .empty     (st_empty)
  );

  // ALU result and carry for the memory-operand ops.
  always_comb begin
    alu_res = dmem_rdata;
    alu_c   = c_q;
    case (aop)
      ALU_ADD: {alu_c, alu_res} = sum_w;
      ALU_SUB: {alu_c, alu_res} = diff_w;
      ALU_AND: alu_res = acc_q & dmem_rdata;
      ALU_OR:  alu_res = acc_q | dmem_rdata;
      ALU_XOR: alu_res = acc_q ^ dmem_rdata;
      default: ;
    endcase
  end

  // Next-state and datapath updates for the FETCH/EXEC/MEM/HALT sequence.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    z_d     = z_q;
    c_d     = c_q;
    err_d   = err_q;
    st_push = 1'b0;
    st_pop  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = uses_mem(op) ? ST_MEM : ST_FETCH;
        case (op)
          OP_LDI: begin
            acc_d = ldi_val;
            z_d   = (ldi_val == '0);
          end
          OP_JMP: pc_d = operand;
          OP_JZ:  if (z_q) pc_d = operand;
          OP_JC:  if (c_q) pc_d = operand;
          OP_CALL: begin
            // Overflow: no push, no jump, fall through to PC+1.
            if (st_full) begin
              err_d = 1'b1;
            end else begin
              st_push = 1'b1;
              pc_d    = operand;
            end
          end
          OP_RET: begin
            if (st_empty) begin
              err_d = 1'b1;
            end else begin
              st_pop = 1'b1;
              pc_d   = st_top;
            end
          end
          OP_SHL: begin
            acc_d = shl_val;
            c_d   = acc_q[DATA_W-1];
            z_d   = (shl_val == '0);
          end
          OP_HALT: state_d = ST_HALT;
          default: ;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_d = ST_FETCH;
          if (aop != ALU_NONE) begin
            acc_d = alu_res;
            z_d   = (alu_res == '0);
            c_d   = alu_c;
          end
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  // Architectural state registers; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      pc_q    <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  // Fetch request is gated by reset so nothing is requested while reset is held.
  assign imem_req   = (state_q == ST_FETCH) && reset;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == ST_MEM);
  assign dmem_we    = dmem_req && (op == OP_STA);
  assign dmem_addr  = operand;
  assign dmem_wdata = acc_q;
  assign acc_out    = acc_q;
  assign pc_out     = pc_q;
  assign z_flag     = z_q;
  assign c_flag     = c_q;
  assign halted     = (state_q == ST_HALT);
  assign stack_err  = err_q;
  assign state_out  = state_q;

endmodule
